// File: rtl/adsr_env_gen_pkg.sv
// adsr_env_gen_pkg: shared ADSR state encoding, register map and envelope unity level.
package synth_pkg;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } adsr_state_t;
    localparam logic [2:0] ADSR_ATK  = 3'd0;
    localparam logic [2:0] ADSR_DEC  = 3'd1;
    localparam logic [2:0] ADSR_SUS  = 3'd2;
    localparam logic [2:0] ADSR_REL  = 3'd3;
    localparam logic [2:0] ADSR_CTRL = 3'd4;
    localparam logic [2:0] ADSR_STAT = 3'd5;
    localparam logic [15:0] ENV_UNITY = 16'h4000;
endpackage

// File: rtl/adsr_env_gen_if.sv
// adsr_env_gen_if: software register bus shared with the DDFS core.
interface adsr_env_gen_if;
    logic        cs;
    logic        sw_read;
    logic        sw_write;
    logic [4:0]  sw_addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    modport master(output cs, sw_read, sw_write, sw_addr, wr_data, input rd_data);
    modport slave(input cs, sw_read, sw_write, sw_addr, wr_data, output rd_data);
endinterface

// File: rtl/adsr_env_gen_regs.sv
// adsr_regs: ADSR register file, address decode, read mux and retrigger pending bit.
module adsr_regs
    import synth_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clken,
    adsr_env_gen_if.slave bus,
    input  adsr_state_t   state,
    input  logic [DW-1:0] env,
    output logic [AW-1:0] atk_step,
    output logic [AW-1:0] dec_step,
    output logic [AW-1:0] rel_step,
    output logic [DW-1:0] sus_level,
    output logic          gate_sel,
    output logic          sw_gate,
    output logic          retrig
);
    logic       wr;
    logic [2:0] a;
    logic       unused;
    assign a      = bus.sw_addr[2:0];
    assign wr     = bus.cs & bus.sw_write;
    assign unused = &{1'b0, bus.sw_read, bus.sw_addr[4:3]};
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            atk_step  <= '0;
            dec_step  <= '0;
            rel_step  <= '0;
            sus_level <= DW'(ENV_UNITY);
            gate_sel  <= 1'b0;
            sw_gate   <= 1'b0;
            retrig    <= 1'b0;
        end else begin
            if (wr && a == ADSR_ATK) atk_step <= bus.wr_data[AW-1:0];
            if (wr && a == ADSR_DEC) dec_step <= bus.wr_data[AW-1:0];
            if (wr && a == ADSR_SUS) sus_level <= bus.wr_data[DW-1:0];
            if (wr && a == ADSR_REL) rel_step <= bus.wr_data[AW-1:0];
            if (wr && a == ADSR_CTRL) {sw_gate, gate_sel} <= bus.wr_data[1:0];
            // retrig is held until the next sample tick consumes it
            retrig <= (wr && a == ADSR_CTRL && bus.wr_data[2]) || (retrig && !clken);
        end
    assign bus.rd_data = a == ADSR_ATK  ? 32'(atk_step) :
                         a == ADSR_DEC  ? 32'(dec_step) :
                         a == ADSR_SUS  ? 32'(sus_level) :
                         a == ADSR_REL  ? 32'(rel_step) :
                         a == ADSR_CTRL ? 32'({sw_gate, gate_sel}) :
                         a == ADSR_STAT ? 32'({state, env}) : 32'd0;
endmodule

// File: rtl/adsr_env_gen.sv
// adsr_env_gen: per-voice ADSR envelope feeding the DDFS env_ext input (unsigned Q2.14).
module adsr_env_gen
    import synth_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clken,
    input  logic          gate_ext,
    adsr_env_gen_if.slave bus,
    output logic [DW-1:0] env_out,
    output logic          active,
    output logic [2:0]    state_out
);
    localparam logic [AW-1:0] PEAK  = AW'(1) << (AW - 2);
    localparam logic [DW-1:0] UNITY = DW'(ENV_UNITY);
    adsr_state_t   state, state_d;
    logic [AW-1:0] acc, acc_d, atk_step, dec_step, rel_step, sus_acc;
    logic [AW:0]   atk_sum, dec_lim;
    logic [DW-1:0] sus_level, sus_c;
    logic          gate_sel, sw_gate, retrig, gate_q, g, rise, fall;
    adsr_regs #(.DW(DW), .AW(AW)) u_regs (
        .clk(clk), .reset(reset), .clken(clken), .bus(bus),
        .state(state), .env(env_out),
        .atk_step(atk_step), .dec_step(dec_step), .rel_step(rel_step),
        .sus_level(sus_level), .gate_sel(gate_sel), .sw_gate(sw_gate), .retrig(retrig)
    );
    assign g       = gate_sel ? gate_ext : sw_gate;
    assign rise    = (g & ~gate_q) | retrig;
    assign fall    = ~g & gate_q;
    assign sus_c   = sus_level > UNITY ? UNITY : sus_level;
    assign sus_acc = AW'(sus_c) << (AW - DW);
    // one extra bit so limit comparisons cannot wrap
    assign atk_sum = {1'b0, acc} + {1'b0, atk_step};
    assign dec_lim = {1'b0, sus_acc} + {1'b0, dec_step};
    always_comb begin
        state_d = state;
        acc_d   = acc;
        if (rise) state_d = ATTACK;
        else if (fall && state != IDLE && state != RELEASE) state_d = RELEASE;
        else
            case (state)
                ATTACK:
                    if (atk_step == '0 || atk_sum >= {1'b0, PEAK}) begin
                        acc_d   = PEAK;
                        state_d = DECAY;
                    end else acc_d = atk_sum[AW-1:0];
                DECAY:
                    if (dec_step == '0 || {1'b0, acc} <= dec_lim) begin
                        acc_d   = sus_acc;
                        state_d = SUSTAIN;
                    end else acc_d = acc - dec_step;
                SUSTAIN: acc_d = sus_acc;
                RELEASE:
                    if (rel_step == '0 || acc <= rel_step) begin
                        acc_d   = '0;
                        state_d = IDLE;
                    end else acc_d = acc - rel_step;
                default: begin
                    acc_d   = '0;
                    state_d = IDLE;
                end
            endcase
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state  <= IDLE;
            acc    <= '0;
            gate_q <= 1'b0;
        end else if (clken) begin
            state  <= state_d;
            acc    <= acc_d;
            gate_q <= g;
        end
    assign env_out   = acc[AW-1:AW-DW];
    assign active    = state != IDLE;
    assign state_out = state;
endmodule
